// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready handshake.
// Captures the add/sub ALU result, flags and control for one instruction.
// A signed overflow on a trapping op suppresses the instruction, parks the
// stage in TRAP and holds exc_req with the faulting PC in epc until exc_ack.
// Optional feature macro: EX_MEM_OVCNT_EN adds a saturating 16-bit
// overflow-trap counter on output ov_count.
module ex_mem_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
`ifdef EX_MEM_OVCNT_EN
    output logic [15:0]      ov_count,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             ov_trap_en,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_reg_wr,
    input  logic             in_mem_rd,
    input  logic             in_mem_wr,
    input  logic [WIDTH-1:0] in_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_wdata,
    output logic             out_z,
    output logic             out_v,
    output logic             out_n,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_reg_wr,
    output logic             out_mem_rd,
    output logic             out_mem_wr,
    output logic             exc_req,
    input  logic             exc_ack,
    output logic [WIDTH-1:0] epc
);

    typedef enum logic [1:0] {EMPTY, FULL, TRAP} state_t;

    state_t state_reg;
    state_t state_next;
    logic   accept;
    logic   trap;
    logic   load;

    // Handshake decode: ready is purely a function of state and downstream ready.
    assign in_ready  = (state_reg == EMPTY) | ((state_reg == FULL) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign trap      = accept & alu_v & ov_trap_en;
    assign load      = accept & ~trap;
    assign out_valid = (state_reg == FULL);
    assign exc_req   = (state_reg == TRAP);

    // State register; reset wins over every other input, including TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. In FULL, accept can only be true when out_ready is high.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (trap) begin
                    state_next = TRAP;
                end else if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (trap) begin
                        state_next = TRAP;
                    end else if (accept) begin
                        state_next = FULL;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            TRAP: begin
                if (exc_ack) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Payload and EPC capture; a trapping instruction never reaches out_*.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_s      <= '0;
            out_pc     <= '0;
            out_wdata  <= '0;
            out_z      <= 1'b0;
            out_v      <= 1'b0;
            out_n      <= 1'b0;
            out_rd     <= '0;
            out_reg_wr <= 1'b0;
            out_mem_rd <= 1'b0;
            out_mem_wr <= 1'b0;
            epc        <= '0;
        end else begin
            if (load) begin
                out_s      <= alu_s;
                out_pc     <= in_pc;
                out_wdata  <= in_wdata;
                out_z      <= alu_z;
                out_v      <= alu_v;
                out_n      <= alu_n;
                out_rd     <= in_rd;
                out_reg_wr <= in_reg_wr;
                out_mem_rd <= in_mem_rd;
                out_mem_wr <= in_mem_wr;
            end
            if (trap) begin
                epc <= in_pc;
            end
        end
    end

`ifdef EX_MEM_OVCNT_EN
    // Saturating count of taken overflow traps (flushed ones never trap).
    always_ff @(posedge clk) begin
        if (reset) begin
            ov_count <= 16'h0000;
        end else if (trap && (ov_count != 16'hFFFF)) begin
            ov_count <= ov_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors for ex_mem_stage with a scoreboard.
// The driver pushes the expected MEM-side entry for every instruction it
// knows will be accepted; a negedge monitor pops and compares on each
// out_valid & out_ready transfer.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush;
    logic [31:0] alu_s;
    logic        alu_z, alu_v, alu_n, ov_trap_en;
    logic [31:0] in_pc, in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_wr, in_mem_rd, in_mem_wr;
    logic        out_valid, out_ready;
    logic [31:0] out_s, out_pc, out_wdata;
    logic        out_z, out_v, out_n;
    logic [4:0]  out_rd;
    logic        out_reg_wr, out_mem_rd, out_mem_wr;
    logic        exc_req, exc_ack;
    logic [31:0] epc;
`ifdef EX_MEM_OVCNT_EN
    logic [15:0] ov_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] s, pc, wdata;
        logic        z, v, n;
        logic [4:0]  rd;
        logic        reg_wr, mem_rd, mem_wr;
    } exp_t;

    exp_t sb[$];

    ex_mem_stage #(.WIDTH(32), .RA_W(5)) dut (
`ifdef EX_MEM_OVCNT_EN
        .ov_count(ov_count),
`endif
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .alu_s(alu_s), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .ov_trap_en(ov_trap_en), .in_pc(in_pc), .in_rd(in_rd),
        .in_reg_wr(in_reg_wr), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .in_wdata(in_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_pc(out_pc), .out_wdata(out_wdata),
        .out_z(out_z), .out_v(out_v), .out_n(out_n), .out_rd(out_rd),
        .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .exc_req(exc_req), .exc_ack(exc_ack), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: one transfer per cycle where MEM takes the entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("xfer pc=%h s=%h rd=%0d v=%b", out_pc, out_s, out_rd, out_v);
                chk("out_s", out_s, e.s);
                chk("out_pc", out_pc, e.pc);
                chk("out_wdata", out_wdata, e.wdata);
                chk("out_flags", {29'd0, out_z, out_v, out_n}, {29'd0, e.z, e.v, e.n});
                chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("out_ctl", {29'd0, out_reg_wr, out_mem_rd, out_mem_wr},
                    {29'd0, e.reg_wr, e.mem_rd, e.mem_wr});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; push expectation if it will be accepted.
    task automatic send(input logic [31:0] s, input logic z, input logic v, input logic n,
                        input logic ten, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [2:0] ctl, input logic [31:0] wd, input bit push);
        exp_t e;
        in_valid = 1'b1; flush = 1'b0;
        alu_s = s; alu_z = z; alu_v = v; alu_n = n; ov_trap_en = ten;
        in_pc = pc; in_rd = rd; {in_reg_wr, in_mem_rd, in_mem_wr} = ctl; in_wdata = wd;
        if (push) begin
            e.s = s; e.pc = pc; e.wdata = wd; e.z = z; e.v = v; e.n = n; e.rd = rd;
            {e.reg_wr, e.mem_rd, e.mem_wr} = ctl;
            sb.push_back(e);
        end
        $display("issue pc=%h s=%h v=%b trap_en=%b push=%0d", pc, s, v, ten, push);
        cyc();
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; alu_v = 1'b0; ov_trap_en = 1'b0;
    endtask

    task automatic do_trap(input logic [31:0] pc);
        send(32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1, pc, 5'd7, 3'b100, 32'h0, 0);
        idle();
        exc_ack = 1'b1;
        cyc();
        exc_ack = 1'b0;
    endtask

    initial begin
        // Reset with arbitrary inputs.
        reset = 1'b1; in_valid = 1'b1; flush = 1'b0; alu_s = 32'hDEADBEEF;
        alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1; ov_trap_en = 1'b1;
        in_pc = 32'h12345678; in_rd = 5'd31; in_reg_wr = 1'b1; in_mem_rd = 1'b1;
        in_mem_wr = 1'b1; in_wdata = 32'hCAFEF00D; out_ready = 1'b0; exc_ack = 1'b1;
        cyc(); cyc();
        reset = 1'b0; idle(); exc_ack = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_exc_req", {31'd0, exc_req}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_out_s", out_s, 32'd0);
        chk("rst_out_pc_wdata", out_pc | out_wdata, 32'd0);
        chk("rst_out_misc", {21'd0, out_rd, out_z, out_v, out_n, out_reg_wr, out_mem_rd, out_mem_wr}, 32'd0);
        cyc();

        // Pass-through then four back-to-back instructions.
        send(32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000100, 5'd3, 3'b100, 32'h0, 1);
        send(32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000104, 5'd4, 3'b100, 32'h11, 1);
        send(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000108, 5'd5, 3'b010, 32'h22, 1);
        send(32'hFFFFFFF0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000010C, 5'd0, 3'b001, 32'h33, 1);
        send(32'h00000040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000110, 5'd9, 3'b100, 32'h44, 1);
        idle();
        cyc(); cyc();
        chk("sb_drained_1", sb.size(), 32'd0);

        // Backpressure.
        out_ready = 1'b0;
        send(32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000200, 5'd1, 3'b100, 32'h0, 1);
        in_valid = 1'b1; alu_s = 32'h00000010; in_pc = 32'h00000204; in_rd = 5'd2;
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        cyc(); cyc();
        chk("bp_hold_s", out_s, 32'h00000008);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        sb.push_back('{s:32'h10, pc:32'h204, wdata:32'h0, z:1'b0, v:1'b0, n:1'b0,
                       rd:5'd2, reg_wr:1'b1, mem_rd:1'b0, mem_wr:1'b0});
        out_ready = 1'b1;
        cyc();
        idle();
        chk("bp_next_s", out_s, 32'h00000010);
        cyc(); cyc();
        chk("sb_drained_2", sb.size(), 32'd0);

        // Signed overflow trap from EMPTY.
        send(32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00400010, 5'd6, 3'b100, 32'h0, 0);
        idle();
        @(negedge clk);
        chk("trap_exc_req", {31'd0, exc_req}, 32'd1);
        chk("trap_epc", epc, 32'h00400010);
        chk("trap_out_valid", {31'd0, out_valid}, 32'd0);
        chk("trap_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        cyc(); cyc(); cyc();
        in_valid = 1'b0;
        chk("trap_held", {31'd0, exc_req}, 32'd1);
        exc_ack = 1'b1;
        cyc();
        exc_ack = 1'b0;
        chk("ack_exc_req", {31'd0, exc_req}, 32'd0);
        chk("ack_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ack_epc_hold", epc, 32'h00400010);

        // Same stimulus, unsigned op: pass-through with V set.
        send(32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00400010, 5'd6, 3'b100, 32'h0, 1);
        idle();
        chk("untrap_exc_req", {31'd0, exc_req}, 32'd0);
        chk("untrap_out_v", {31'd0, out_v}, 32'd1);
        cyc();

        // Trap from FULL: old entry consumed, new one suppressed.
        send(32'h00000055, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000300, 5'd8, 3'b100, 32'h0, 1);
        send(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000304, 5'd8, 3'b100, 32'h0, 0);
        idle();
        chk("full_trap_exc", {31'd0, exc_req}, 32'd1);
        chk("full_trap_epc", epc, 32'h00000304);
        exc_ack = 1'b1;
        cyc();
        exc_ack = 1'b0;
        chk("sb_drained_3", sb.size(), 32'd0);

        // Flush in EMPTY, then flush while FULL under backpressure.
        in_valid = 1'b1; flush = 1'b1; alu_s = 32'h0000AAAA;
        cyc();
        idle();
        chk("flush_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        send(32'h00000077, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000400, 5'd12, 3'b001, 32'h99, 1);
        in_valid = 1'b1; flush = 1'b1; alu_s = 32'h0000BBBB; in_pc = 32'h404;
        cyc();
        chk("flush_full_s", out_s, 32'h00000077);
        idle();
        out_ready = 1'b1;
        cyc(); cyc();
        chk("sb_drained_4", sb.size(), 32'd0);

        // Reset while in TRAP.
        send(32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000500, 5'd1, 3'b100, 32'h0, 0);
        idle();
        chk("pre_rst_trap", {31'd0, exc_req}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midtrap_exc_req", {31'd0, exc_req}, 32'd0);
        chk("midtrap_epc", epc, 32'd0);
        chk("midtrap_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef EX_MEM_OVCNT_EN
        do_trap(32'h600);
        do_trap(32'h604);
        // Flushed overflowing instruction is not counted.
        in_valid = 1'b1; flush = 1'b1; alu_v = 1'b1; ov_trap_en = 1'b1;
        cyc();
        idle();
        do_trap(32'h608);
        chk("ov_count_3", {16'd0, ov_count}, 32'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("ov_count_rst", {16'd0, ov_count}, 32'd0);
`else
        do_trap(32'h600);
        chk("post_trap_epc", epc, 32'h00000600);
`endif

        cyc(); cyc();
        chk("sb_final", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute-stage add/sub ALU and the memory stage.
- Captures the ALU result, flags and control for one instruction, with a valid/ready handshake toward MEM.
- Intercepts signed arithmetic overflow: the faulting instruction is suppressed, the stage stalls, and it raises a held exception request with the captured EPC.
- Sole consumer of the ALU's S/Z/V/N outputs.

Parameters:
- WIDTH, 32, datapath width (ALU result, PC, store data).
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock (all state updates on rising edge)
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EX holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- flush  in  1  squash the instruction presented this cycle
- alu_s  in  WIDTH  ALU sum/difference
- alu_z  in  1  ALU zero flag
- alu_v  in  1  ALU overflow flag
- alu_n  in  1  ALU negative flag
- ov_trap_en  in  1  instruction is signed add/sub (overflow traps)
- in_pc  in  WIDTH  instruction PC
- in_rd  in  RA_W  destination register
- in_reg_wr  in  1  register-write enable
- in_mem_rd  in  1  load
- in_mem_wr  in  1  store
- in_wdata  in  WIDTH  store data
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes entry
- out_s, out_pc, out_wdata  out  WIDTH  latched copies
- out_z, out_v, out_n  out  1  latched flags
- out_rd  out  RA_W  latched destination register
- out_reg_wr, out_mem_rd, out_mem_wr  out  1  latched controls
- exc_req  out  1  overflow exception request (level, held)
- exc_ack  in  1  exception unit acknowledges
- epc  out  WIDTH  PC of the overflowing instruction

Behaviour:
- States: EMPTY, FULL, TRAP. Reset (sync) forces EMPTY; every output register clears to 0, including out_*, exc_req and epc. Reset overrides all other inputs, including mid-TRAP.
- in_ready = (state==EMPTY) | (state==FULL & out_ready). It is 0 in TRAP. It is combinational, with no dependency on in_valid.
- accept = in_valid & in_ready & ~flush. The flushed instruction is dropped silently; flush never affects an entry already held.
- trap = accept & alu_v & ov_trap_en. With ov_trap_en=0 (unsigned ops), V is only passed through and never traps.
- EMPTY:
  - On trap: go to TRAP and set epc<=in_pc. out_* are not loaded and out_valid stays 0.
  - On accept without trap: load all out_* and go to FULL.
  - Otherwise: stay in EMPTY.
- FULL (out_valid=1, out_* stable while out_ready=0):
  - out_ready & accept & ~trap: reload and stay FULL. Back-to-back throughput is 1 per cycle.
  - out_ready & trap: go to TRAP and set epc<=in_pc. The old entry is consumed that cycle.
  - out_ready & ~accept: go to EMPTY.
  - ~out_ready: hold.
- TRAP (exc_req=1, out_valid=0, in_ready=0):
  - exc_req stays high until exc_ack is sampled high, then go to EMPTY with exc_req=0 next cycle.
  - epc holds until the next trap.
- exc_ack outside TRAP is ignored.
- out_valid = (state==FULL); exc_req = (state==TRAP). Both are registered state decodes.
- Latency: accept in cycle t → out_valid/exc_req visible in cycle t+1.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro EX_MEM_OVCNT_EN.
- When defined:
  - Adds output ov_count (16 bits).
  - Increments on every trap (accepted cycle) and saturates at 0xFFFF.
  - Resets to 0; flushed overflowing instructions are not counted.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: assert reset 2 cycles during arbitrary inputs → out_valid=0, in_ready=1, exc_req=0, epc=0, all out_*=0.
- Pass-through: in_valid=1, alu_s=0x00000008, in_rd=3, in_reg_wr=1, out_ready=1 → next cycle out_valid=1, out_s=8, out_rd=3. Four back-to-back instructions emerge one per cycle in order.
- Backpressure: FULL with out_s=0x8, out_ready=0, new in_valid with alu_s=0x10 → in_ready=0 and out_s holds 0x8. When out_ready=1, 0x10 appears the following cycle.
- Signed overflow:
  - Stimulus: alu_s=0x80000000, alu_v=1, ov_trap_en=1, in_pc=0x00400010.
  - Next cycle: exc_req=1, epc=0x00400010, out_valid=0, in_ready=0.
  - Hold exc_ack=0 for 3 cycles, then assert it: exc_req is 0 one cycle later and in_ready=1.
  - Same stimulus with ov_trap_en=0 → normal FULL with out_v=1, no exc_req.
- Flush: flush=1 with in_valid=1 → nothing captured (state stays EMPTY). flush=1 while FULL with out_ready=0 → held entry unchanged.
- Reset mid-TRAP: reset while exc_req=1 → next cycle exc_req=0, epc=0, in_ready=1. With EX_MEM_OVCNT_EN: 3 traps → ov_count=3; reset → 0.
